// File: rtl/msgPass_config_pkg.sv
// ---------------------------------------------------------------------------
// msgPass_config_pkg
//
// Purpose:
//   Shared configuration for the message-passing buffer blocks: buffer
//   geometry (depth, read-data width, address width), the page-writer FSM
//   state type, and a small address helper used by the writer.
//
// Contents:
//   MSGPASS_BUFF_DEPTH        number of buffer pages
//   MSGPASS_BUFF_RDATA_WIDTH  page width in bits
//   MSGPASS_BUFF_ADDR_WIDTH   buffer address width
//   msgPass_wr_state_e        page-writer FSM states (IDLE, LOAD, ARM)
//   wrapNext()                next page index with wrap at the buffer depth
// ---------------------------------------------------------------------------
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_DEPTH       = 16;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 32;
  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 4;

  // Writer FSM: IDLE waits for a start, LOAD accepts words, ARM presents the
  // final write and then hands over to the read side.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_LOAD = 2'd1,
    WR_ARM  = 2'd2
  } msgPass_wr_state_e;

  // Page index following 'addr' in a circular buffer of 'depth' pages.
  // The buffer depth need not be a power of two, so the wrap is explicit
  // instead of relying on natural counter overflow.
  function automatic int wrapNext(input int addr, input int depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/msgpass_buff_writer.sv
// ---------------------------------------------------------------------------
// msgpass_buff_writer
//
// Purpose:
//   Loads a sequence of words from an upstream valid/ready source into
//   consecutive pages of a circular message buffer, then pulses read_begin_o
//   so the read-address generator can start draining the freshly written
//   pages.
//
// Parameters:
//   BUFF_DEPTH   number of buffer pages
//   DATA_WIDTH   page width in bits
//   ADDR_WIDTH   buffer address width
//
// Ports:
//   sys_clk        single clock, all logic on the rising edge
//   rstn           asynchronous active-low reset
//   start_i        one-cycle pulse arming a load sequence (IDLE only)
//   seq_len_i      number of pages to write, sampled with start_i
//   base_addr_i    first page address, sampled with start_i
//   clear_i        synchronous abort back to IDLE, beats start_i
//   wr_valid_i     upstream word valid
//   wr_data_i      upstream word
//   wr_ready_o     word accepted when wr_valid_i and wr_ready_o are both high
//   waddr_o        buffer write address (registered)
//   wdata_o        buffer write data (registered)
//   wen_o          buffer write enable, active low (registered)
//   read_begin_o   one-cycle pulse after the last page is written
//   busy_o         high whenever the writer is not in IDLE
//   err_o          sticky protocol error flag
//
// Configuration:
//   MSGPASS_BUFF_WRITER_ERR_EN  when defined, err_o flags illegal starts,
//                               starts while busy and valid words in IDLE;
//                               when undefined err_o is constant 0.
// ---------------------------------------------------------------------------
module msgpass_buff_writer
  import msgPass_config_pkg::*;
#(
  parameter int BUFF_DEPTH = MSGPASS_BUFF_DEPTH,
  parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
  parameter int ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   seq_len_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  clear_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wen_o,
  output logic                  read_begin_o,
  output logic                  busy_o,
  output logic                  err_o
);

  msgPass_wr_state_e     state;
  logic [ADDR_WIDTH:0]   seqLen;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   countNext;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic                  startLegal;
  logic                  accept;

  // A sequence length is usable only if it names at least one page and no
  // more pages than the buffer holds; the one extra bit on the length and
  // count is what lets a full-buffer sequence be expressed.
  assign startLegal = (seq_len_i != '0) &&
                      (seq_len_i <= (ADDR_WIDTH+1)'(BUFF_DEPTH));

  // Ready is withheld during clear_i so that a word can never be handshaken
  // in the same cycle that the sequence is being thrown away.
  assign wr_ready_o = (state == WR_LOAD) && (count < seqLen) && !clear_i;
  assign accept     = wr_valid_i && wr_ready_o;
  assign countNext  = count + (ADDR_WIDTH+1)'(1);
  assign busy_o     = (state != WR_IDLE);

  // Sequence control: latch length and base address on a legal start,
  // advance the page pointer per accepted word, and leave LOAD once the
  // final word has been taken. ARM always lasts exactly one cycle.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= WR_IDLE;
      seqLen   <= '0;
      count    <= '0;
      nextAddr <= '0;
    end else if (clear_i) begin
      state <= WR_IDLE;
      count <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (start_i && startLegal) begin
            state    <= WR_LOAD;
            seqLen   <= seq_len_i;
            nextAddr <= base_addr_i;
            count    <= '0;
          end
        end
        WR_LOAD: begin
          if (accept) begin
            count    <= countNext;
            nextAddr <= ADDR_WIDTH'(wrapNext(int'(nextAddr), BUFF_DEPTH));
            if (countNext == seqLen) begin
              state <= WR_ARM;
            end
          end
        end
        WR_ARM: begin
          state <= WR_IDLE;
        end
        default: begin
          state <= WR_IDLE;
        end
      endcase
    end
  end

  // Buffer write port: an accepted word is presented one cycle later with
  // wen_o low. Address and data are only loaded on a write so the port keeps
  // its last value while idle.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wen_o   <= 1'b1;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (accept) begin
      wen_o   <= 1'b0;
      waddr_o <= nextAddr;
      wdata_o <= wr_data_i;
    end else begin
      wen_o <= 1'b1;
    end
  end

  // The read side is told to begin as the writer leaves ARM, i.e. the cycle
  // after the last page write is on the port. An abort during ARM suppresses
  // the pulse.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      read_begin_o <= 1'b0;
    end else begin
      read_begin_o <= (state == WR_ARM) && !clear_i;
    end
  end

`ifdef MSGPASS_BUFF_WRITER_ERR_EN
  logic errFlag;

  // Sticky protocol error: illegal length on a start, a start while a
  // sequence is running, or upstream presenting data with nothing armed.
  // Only reset or clear_i brings it back down.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      errFlag <= 1'b0;
    end else if (clear_i) begin
      errFlag <= 1'b0;
    end else if ((start_i && ((state != WR_IDLE) || !startLegal)) ||
                 (wr_valid_i && (state == WR_IDLE))) begin
      errFlag <= 1'b1;
    end
  end

  assign err_o = errFlag;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_msgpass_buff_writer.sv
// ---------------------------------------------------------------------------
// tb_msgpass_buff_writer
//
// Drives msgpass_buff_writer (5 pages, so address wrap is easy to reach)
// with directed and random sequences. The driver keeps a transaction-level
// model of the writer and pushes the expected page writes, read_begin
// pulses and per-cycle status into a scoreboard; an independent monitor
// compares the DUT against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_msgpass_buff_writer;

  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic          start_i;
  logic [AW:0]   seq_len_i;
  logic [AW-1:0] base_addr_i;
  logic          clear_i;
  logic          wr_valid_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          wen_o;
  logic          read_begin_o;
  logic          busy_o;
  logic          err_o;

  msgpass_buff_writer #(
    .BUFF_DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .seq_len_i   (seq_len_i),
    .base_addr_i (base_addr_i),
    .clear_i     (clear_i),
    .wr_valid_i  (wr_valid_i),
    .wr_data_i   (wr_data_i),
    .wr_ready_o  (wr_ready_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .wen_o       (wen_o),
    .read_begin_o(read_begin_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index: cycle n is the interval following the n-th rising edge.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  // Scoreboard
  wr_t wq[$];
  int  rbq[$];
  bit  expBusy[int];
  bit  expRdy[int];
  bit  expErr[int];
  int  lastAddr = 0;
  int  lastData = 0;

  // Reference model: one running sequence described by its length, base page
  // and how many words it has taken, plus whether the hand-off is pending.
  bit mLoading = 1'b0;
  bit mArmed   = 1'b0;
  bit mErr     = 1'b0;
  int mLen     = 0;
  int mBase    = 0;
  int mCount   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    else
      passes++;
  endtask

  // Monitor: compares the DUT against the scoreboard each cycle.
  always @(negedge sys_clk) begin
    int  n;
    bit  rbExp;
    n = cyc;
    if (rstn === 1'b1) begin
      if (expBusy.exists(n)) begin
        checkOutput("busy", busy_o, expBusy[n]);
        checkOutput("ready", wr_ready_o, expRdy[n]);
        checkOutput("err", err_o, expErr[n]);
        expBusy.delete(n);
      end
      if (wq.size() > 0 && wq[0].due == n) begin
        checkOutput("wen", wen_o, 0);
        checkOutput("waddr", waddr_o, wq[0].addr);
        checkOutput("wdata", wdata_o, wq[0].data);
        lastAddr = wq[0].addr;
        lastData = wq[0].data;
        void'(wq.pop_front());
      end else begin
        checkOutput("wenIdle", wen_o, 1);
        checkOutput("waddrHold", waddr_o, lastAddr);
        checkOutput("wdataHold", wdata_o, lastData);
      end
      rbExp = (rbq.size() > 0) && (rbq[0] == n);
      checkOutput("readBegin", read_begin_o, rbExp);
      if (rbExp) void'(rbq.pop_front());
    end
  end

  // Drive one cycle of inputs and advance the reference model.
  task automatic applyStimulus(input bit st, input int len, input int base,
                               input bit clr, input bit vld, input int data);
    int  c;
    bit  busyNow;
    bit  rdyNow;
    bit  legal;
    wr_t w;
    start_i     = st;
    seq_len_i   = (AW+1)'(len);
    base_addr_i = AW'(base);
    clear_i     = clr;
    wr_valid_i  = vld;
    wr_data_i   = DW'(data);
    c       = cyc;
    busyNow = mLoading || mArmed;
    rdyNow  = mLoading && !clr;
    legal   = (len >= 1) && (len <= DEPTH);
    expBusy[c] = busyNow;
    expRdy[c]  = rdyNow;
    expErr[c]  = mErr;
    if (clr) begin
      mLoading = 1'b0;
      mArmed   = 1'b0;
      mErr     = 1'b0;
    end else begin
      if (mArmed) begin
        mArmed = 1'b0;
        rbq.push_back(c + 1);
      end
      if (vld && rdyNow) begin
        w.due  = c + 1;
        w.addr = (mBase + mCount) % DEPTH;
        w.data = data % 65536;
        wq.push_back(w);
        mCount++;
        if (mCount == mLen) begin
          mLoading = 1'b0;
          mArmed   = 1'b1;
        end
      end
      if (!busyNow && st && legal) begin
        mLoading = 1'b1;
        mLen     = len;
        mBase    = base;
        mCount   = 0;
      end
`ifdef MSGPASS_BUFF_WRITER_ERR_EN
      if ((st && (busyNow || !legal)) || (vld && !busyNow)) mErr = 1'b1;
`endif
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic startSeq(input int len, input int base);
    applyStimulus(1, len, base, 0, 0, 0);
  endtask

  task automatic words(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, int'($urandom_range(0, 65535)));
  endtask

  // Asynchronous reset taken mid-cycle; outputs must drop immediately.
  task automatic resetPulse();
    rstn        = 1'b0;
    start_i     = 1'b0;
    seq_len_i   = '0;
    base_addr_i = '0;
    clear_i     = 1'b0;
    wr_valid_i  = 1'b0;
    wr_data_i   = '0;
    #1;
    checkOutput("rstWen", wen_o, 1);
    checkOutput("rstReady", wr_ready_o, 0);
    checkOutput("rstReadBegin", read_begin_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstErr", err_o, 0);
    checkOutput("rstWaddr", waddr_o, 0);
    checkOutput("rstWdata", wdata_o, 0);
    wq.delete();
    rbq.delete();
    mLoading = 1'b0;
    mArmed   = 1'b0;
    mErr     = 1'b0;
    lastAddr = 0;
    lastData = 0;
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn        = 1'b0;
    start_i     = 1'b0;
    seq_len_i   = '0;
    base_addr_i = '0;
    clear_i     = 1'b0;
    wr_valid_i  = 1'b0;
    wr_data_i   = '0;
    @(posedge sys_clk);
    #1;
    resetPulse();
    idle(2);

    // Basic load of three words at page 0
    startSeq(3, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hA0A0);
    applyStimulus(0, 0, 0, 0, 1, 16'hB1B1);
    applyStimulus(0, 0, 0, 0, 1, 16'hC2C2);
    idle(3);

    // Wrap from the last page back to page 0
    startSeq(4, 3);
    words(4);
    idle(3);

    // Gaps in valid; extra valid after the last word must not be taken
    startSeq(3, 1);
    applyStimulus(0, 0, 0, 0, 1, 16'h1111);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h2222);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h3333);
    applyStimulus(0, 0, 0, 0, 1, 16'h4444);
    applyStimulus(0, 0, 0, 1, 1, 16'h5555);
    idle(2);

    // Abort after two of four words, then a normal sequence
    startSeq(4, 0);
    words(2);
    applyStimulus(0, 0, 0, 1, 1, 16'h7777);
    idle(1);
    startSeq(2, 4);
    words(2);
    idle(3);

    // Illegal lengths, then a full-buffer sequence
    startSeq(0, 1);
    idle(2);
    startSeq(DEPTH + 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 1, 0, 0);
    startSeq(DEPTH, 2);
    words(DEPTH);
    idle(3);

    // Start while loading is ignored
    startSeq(3, 0);
    words(1);
    applyStimulus(1, 2, 4, 0, 1, 16'h9999);
    words(2);
    idle(3);

    // Clear and start in the same cycle: clear wins
    applyStimulus(1, 2, 0, 1, 0, 0);
    idle(2);

    // Reset after one word, then a normal sequence
    startSeq(4, 1);
    words(1);
    resetPulse();
    idle(2);
    startSeq(2, 0);
    words(2);
    idle(3);

    // Random traffic
    for (int s = 0; s < 60; s++) begin
      startSeq(int'($urandom_range(0, DEPTH + 1)), int'($urandom_range(0, DEPTH - 1)));
      for (int k = 0; k < 12; k++) begin
        applyStimulus($urandom_range(0, 15) == 0,
                      int'($urandom_range(0, DEPTH + 1)),
                      int'($urandom_range(0, DEPTH - 1)),
                      $urandom_range(0, 40) == 0,
                      $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 65535)));
      end
      if ($urandom_range(0, 19) == 0) resetPulse();
      idle(2);
    end

    idle(4);
    checkOutput("drainWrites", wq.size(), 0);
    checkOutput("drainReadBegin", rbq.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
